// File: rtl/node_xchg_multi.sv
// Replica-exchange controller: holds per-channel tour totals, applies deltas, swaps with the neighbour node.
// Exchange takes 3 cycles after ex_start (busy 1-3, done on 3); no backpressure, deltas arriving while busy are dropped and flagged.
module node_xchg_multi #(
    parameter int NUM_CH = 2,
    parameter int ROT    = 1,
    parameter int DIS_W  = 24,
    parameter int LIM_W  = 16,
    parameter int BASE_W = 4,
    parameter int ID     = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [BASE_W-1:0]       base_id,
    input  logic                    is_first,
    input  logic                    is_last,
    input  logic                    distance_shift,
    input  logic [DIS_W-1:0]        shift_in_dis,
    output logic [DIS_W-1:0]        shift_out_dis,
    input  logic [NUM_CH-1:0]       dis_update,
    input  logic [NUM_CH*DIS_W-1:0] dis_delta,
    input  logic                    ex_start,
    input  logic                    ex_parity,
    input  logic [NUM_CH*LIM_W-1:0] accept_lim,
    input  logic [NUM_CH*DIS_W-1:0] prev_dis,
    input  logic [NUM_CH*DIS_W-1:0] folw_dis,
    output logic [NUM_CH*DIS_W-1:0] out_dis,
    input  logic [NUM_CH-1:0]       prev_exchange,
    output logic [NUM_CH-1:0]       out_exchange,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);
    localparam int CW = (DIS_W + 1 > LIM_W) ? DIS_W + 1 : LIM_W;

    typedef enum logic [1:0] {IDLE, CMP, DEC, SWAP} state_t;
    state_t state_q, state_d;

    logic [BASE_W:0]   node_idx;
    logic              unused_base;
    logic              lower_now;
    logic              ex_go;
    logic              lower_q;
    logic              nopart_q;
    logic              err_q;
    logic [NUM_CH-1:0] xchg_q;
    logic [NUM_CH-1:0] acc_lo;
    logic [NUM_CH-1:0] acc_dec;
    logic [DIS_W-1:0]  tot_q    [NUM_CH];
    logic [DIS_W-1:0]  part_q   [NUM_CH];
    logic [DIS_W-1:0]  part_sel [NUM_CH];
    logic [DIS_W-1:0]  sum      [NUM_CH];

    assign node_idx    = {base_id, 1'(ID % 2)};
    assign unused_base = ^node_idx;
    assign lower_now   = (node_idx[0] == ex_parity);
    assign ex_go       = (state_q == IDLE) && ex_start && !distance_shift;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        localparam int J = (NUM_CH == 1) ? 0 : (k + ROT) % NUM_CH;
        logic [DIS_W:0] diff;
        logic [DIS_W:0] mag;

        assign part_sel[k] = lower_q ? folw_dis[J*DIS_W +: DIS_W] : prev_dis[J*DIS_W +: DIS_W];
        assign diff        = {1'b0, tot_q[k]} - {1'b0, part_sel[k]};
        assign mag         = -diff;
        // d>0 always accepts; d<0 accepts only when |d| is under the limit; d==0 rejects
        assign acc_lo[k]   = (diff != '0) &&
                             (!diff[DIS_W] || (CW'(mag) < CW'(accept_lim[k*LIM_W +: LIM_W])));
        assign acc_dec[k]  = !nopart_q && (lower_q ? xchg_q[k] : prev_exchange[J]);
        assign sum[k]      = tot_q[k] + dis_delta[k*DIS_W +: DIS_W];
        assign out_dis[k*DIS_W +: DIS_W] = tot_q[k];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ex_start) state_d = CMP;
            CMP:     state_d = DEC;
            DEC:     state_d = SWAP;
            SWAP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (distance_shift) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            lower_q  <= 1'b0;
            nopart_q <= 1'b0;
            xchg_q   <= '0;
            err_q    <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                tot_q[k]  <= '0;
                part_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (ex_go) begin
                lower_q  <= lower_now;
                nopart_q <= lower_now ? is_last : is_first;
            end
            xchg_q <= '0;
            if (distance_shift) begin
                tot_q[0] <= shift_in_dis;
                for (int k = 1; k < NUM_CH; k++) tot_q[k] <= tot_q[k-1];
            end else begin
                if (state_q == CMP) begin
                    for (int k = 0; k < NUM_CH; k++) part_q[k] <= part_sel[k];
                    if (lower_q && !nopart_q) xchg_q <= acc_lo;
                end
                // swapped totals land on entry to SWAP so they are visible alongside done
                for (int k = 0; k < NUM_CH; k++) begin
                    if (state_q == DEC && acc_dec[k])
                        tot_q[k] <= part_q[k];
                    else if (state_q == IDLE && dis_update[k])
                        tot_q[k] <= sum[k];
                end
                if (state_q != IDLE && |dis_update) err_q <= 1'b1;
            end
        end
    end

    assign shift_out_dis = tot_q[NUM_CH-1];
    assign out_exchange  = xchg_q;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == SWAP);
    assign err           = err_q;
endmodule

// File: tb/tb_node_xchg_multi.sv
// Directed bench for node_xchg_multi with NUM_CH=2, ROT=1, node index 0.
module tb_node_xchg_multi;
    localparam int NC = 2;
    localparam int DW = 24;
    localparam int LW = 16;
    localparam int BW = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [BW-1:0]    base_id;
    logic             is_first, is_last, distance_shift;
    logic [DW-1:0]    shift_in_dis, shift_out_dis;
    logic [NC-1:0]    dis_update;
    logic [NC*DW-1:0] dis_delta;
    logic             ex_start, ex_parity;
    logic [NC*LW-1:0] accept_lim;
    logic [NC*DW-1:0] prev_dis, folw_dis, out_dis;
    logic [NC-1:0]    prev_exchange, out_exchange;
    logic             busy, done, err;

    int checks   = 0;
    int failures = 0;
    logic [1:0] xo;
    logic       dn;

    node_xchg_multi #(.NUM_CH(NC), .ROT(1), .DIS_W(DW), .LIM_W(LW), .BASE_W(BW), .ID(0)) dut (
        .clk(clk), .reset(reset), .base_id(base_id), .is_first(is_first), .is_last(is_last),
        .distance_shift(distance_shift), .shift_in_dis(shift_in_dis), .shift_out_dis(shift_out_dis),
        .dis_update(dis_update), .dis_delta(dis_delta), .ex_start(ex_start), .ex_parity(ex_parity),
        .accept_lim(accept_lim), .prev_dis(prev_dis), .folw_dis(folw_dis), .out_dis(out_dis),
        .prev_exchange(prev_exchange), .out_exchange(out_exchange), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "bench did not finish");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // leaves tot0=a0, tot1=a1
    task automatic load(input logic [DW-1:0] a0, input logic [DW-1:0] a1);
        distance_shift = 1'b1;
        shift_in_dis   = a1;
        tick();
        shift_in_dis   = a0;
        tick();
        distance_shift = 1'b0;
    endtask

    task automatic run_ex(output logic [1:0] x, output logic d);
        ex_start = 1'b1;
        tick();
        ex_start = 1'b0;
        tick();
        x = out_exchange;
        tick();
        d = done;
        tick();
    endtask

    initial begin
        reset = 1'b1; base_id = 4'd0; is_first = 1'b0; is_last = 1'b0;
        distance_shift = 1'b0; shift_in_dis = '0; dis_update = '0; dis_delta = '0;
        ex_start = 1'b0; ex_parity = 1'b0; accept_lim = '0; prev_dis = '0; folw_dis = '0;
        prev_exchange = '0;
        tick();
        chk("rst_out_dis", out_dis, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_xchg", out_exchange, 0);
        reset = 1'b0;
        tick();

        // lower member, both channels accept by d>0
        load(24'd100, 24'd50);
        folw_dis = {24'd70, 24'd40};
        ex_start = 1'b1;
        chk("t2_c0_busy", busy, 0);
        tick();
        ex_start = 1'b0;
        chk("t2_c1_busy", busy, 1);
        chk("t2_c1_xchg", out_exchange, 0);
        tick();
        chk("t2_c2_xchg", out_exchange, 2'b11);
        chk("t2_c2_done", done, 0);
        tick();
        chk("t2_c3_done", done, 1);
        chk("t2_c3_tot0", out_dis[23:0], 70);
        chk("t2_c3_tot1", out_dis[47:24], 40);
        chk("t2_c3_xchg", out_exchange, 0);
        tick();
        chk("t2_c4_busy", busy, 0);
        chk("t2_c4_done", done, 0);

        // Metropolis limit on ch0 (d=-5); ch1 has d=0 and always rejects
        load(24'd30, 24'd0);
        folw_dis   = {24'd35, 24'd0};
        accept_lim = {16'd100, 16'd5};
        run_ex(xo, dn);
        chk("t3_lim5_xchg", xo, 2'b00);
        chk("t3_lim5_tot0", out_dis[23:0], 30);
        accept_lim = {16'd100, 16'd6};
        run_ex(xo, dn);
        chk("t3_lim6_xchg", xo, 2'b01);
        chk("t3_lim6_tot0", out_dis[23:0], 35);
        chk("t3_lim6_tot1", out_dis[47:24], 0);

        // upper member follows prev_exchange through the rotation
        load(24'd5, 24'd6);
        ex_parity     = 1'b1;
        prev_dis      = {24'd77, 24'd88};
        prev_exchange = 2'b10;
        run_ex(xo, dn);
        chk("t4_up_xchg", xo, 0);
        chk("t4_up_tot0", out_dis[23:0], 77);
        chk("t4_up_tot1", out_dis[47:24], 6);
        prev_exchange = 2'b00;

        // lower member at the end of the chain never exchanges
        ex_parity = 1'b0;
        is_last   = 1'b1;
        folw_dis  = {24'd1, 24'd1};
        run_ex(xo, dn);
        chk("t4_last_xchg", xo, 0);
        chk("t4_last_done", dn, 1);
        chk("t4_last_tot0", out_dis[23:0], 77);
        chk("t4_last_tot1", out_dis[47:24], 6);

        // negative delta wraps modulo 2^24
        load(24'd10, 24'd0);
        dis_update = 2'b01;
        dis_delta  = {24'd0, 24'hFFFFEC};
        tick();
        dis_update = '0;
        tick();
        chk("t5_wrap_tot0", out_dis[23:0], 24'hFFFFF6);
        chk("t5_err_clear", err, 0);
        ex_start = 1'b1;
        tick();
        ex_start   = 1'b0;
        dis_update = 2'b10;
        dis_delta  = {24'd5, 24'd0};
        tick();
        dis_update = '0;
        chk("t5_err_set", err, 1);
        tick();
        tick();
        tick();
        chk("t5_busy_tot1", out_dis[47:24], 0);
        chk("t5_err_sticky", err, 1);
        is_last = 1'b0;

        // shift during CMP aborts the exchange
        load(24'd0, 24'd0);
        folw_dis = {24'd0, 24'd0};
        ex_start = 1'b1;
        tick();
        ex_start = 1'b0;
        chk("t6_cmp_busy", busy, 1);
        distance_shift = 1'b1;
        shift_in_dis   = 24'd1;
        chk("t6_so0", shift_out_dis, 0);
        tick();
        chk("t6_abort_busy", busy, 0);
        chk("t6_abort_done", done, 0);
        chk("t6_so1", shift_out_dis, 0);
        shift_in_dis = 24'd2;
        tick();
        chk("t6_so2", shift_out_dis, 1);
        shift_in_dis = 24'd3;
        tick();
        chk("t6_so3", shift_out_dis, 2);
        shift_in_dis = 24'd4;
        tick();
        distance_shift = 1'b0;
        chk("t6_tot0", out_dis[23:0], 4);
        chk("t6_tot1", out_dis[47:24], 3);
        tick();
        chk("t6_no_done", done, 0);
        chk("t6_idle_xchg", out_exchange, 0);

        // asynchronous reset in the middle of DEC
        ex_start = 1'b1;
        tick();
        ex_start = 1'b0;
        tick();
        chk("t1_dec_xchg", out_exchange, 2'b11);
        #2;
        reset = 1'b1;
        #1;
        chk("t1_out_dis", out_dis, 0);
        chk("t1_xchg", out_exchange, 0);
        chk("t1_busy", busy, 0);
        chk("t1_err", err, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("t1_post_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
